// File: rtl/program_writer_pkg.sv
// Shared definitions for the program loader and the fetch/execute core:
// loader FSM states, instruction opcodes and little-endian byte-lane pick.
package program_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_WR1  = 3'd2,
        S_WR2  = 3'd3,
        S_WR3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Opcodes as seen by the core's fetch (byte p of each instruction).
    localparam logic [7:0] OP_MOV_RC   = 8'd1;  // mov reg,const
    localparam logic [7:0] OP_MOV_RM   = 8'd2;  // mov reg,[addr]
    localparam logic [7:0] OP_MOV_MR   = 8'd3;  // mov [addr],reg
    localparam logic [7:0] OP_ADD      = 8'd4;
    localparam logic [7:0] OP_SETDEBUG = 8'd5;
    localparam logic [7:0] OP_FADD     = 8'd6;
    localparam logic [7:0] OP_FSUB     = 8'd7;

    // Byte k of a word, little-endian (k=0 is bits [7:0]).
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/program_writer.sv
// Streams 32-bit words into a byte-wide RAM as four little-endian bytes,
// starting at address 0, in the same order the core fetches them.
module program_writer
    import program_writer_pkg::*;
#(
    parameter int RAMSIZE = 64,
    parameter int ADDRW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    input  logic             in_last,
    input  logic             restart,
    output logic             ram_we,
    output logic [ADDRW-1:0] ram_addr,
    output logic [7:0]       ram_wdata,
    output logic             load_done,
    output logic             overflow,
    output logic [ADDRW:0]   byte_count
);

    // One extra bit so ptr+4 can exceed RAMSIZE without wrapping.
    localparam logic [ADDRW:0] RAM_END = (ADDRW+1)'(RAMSIZE);

    state_t         state;
    logic [ADDRW:0] ptr;
    logic [ADDRW:0] ptr_plus4;
    logic [31:0]    word_q;
    logic           last_q;
    logic           fits;
    logic [1:0]     cur_lane;
    logic [1:0]     nxt_lane;

    assign ptr_plus4 = ptr + (ADDRW+1)'(4);
    assign fits      = (ptr_plus4 <= RAM_END);
    assign nxt_lane  = cur_lane + 2'd1;

    // Byte lane currently presented on the RAM port.
    always_comb begin
        cur_lane = 2'd0;
        case (state)
            S_WR1:   cur_lane = 2'd1;
            S_WR2:   cur_lane = 2'd2;
            S_WR3:   cur_lane = 2'd3;
            default: cur_lane = 2'd0;
        endcase
    end

    // Loader FSM; every output is set here for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            in_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else if (restart) begin
            // Abandons any word in progress; bytes already written stay in RAM.
            state      <= S_IDLE;
            ptr        <= '0;
            in_ready   <= 1'b1;
            ram_we     <= 1'b0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (!fits) begin
                            overflow <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            word_q     <= in_word;
                            last_q     <= in_last;
                            ram_we     <= 1'b1;
                            ram_addr   <= ptr[ADDRW-1:0];
                            ram_wdata  <= byte_lane(in_word, 2'd0);
                            byte_count <= ptr;
                            state      <= S_WR0;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_WR0, S_WR1, S_WR2: begin
                    ram_addr   <= ptr[ADDRW-1:0] + ADDRW'(nxt_lane);
                    ram_wdata  <= byte_lane(word_q, nxt_lane);
                    byte_count <= ptr + (ADDRW+1)'(nxt_lane);
                    state      <= state_t'(state + 3'd1);
                end
                S_WR3: begin
                    ram_we     <= 1'b0;
                    ptr        <= ptr_plus4;
                    byte_count <= ptr_plus4;
                    if (last_q) begin
                        load_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    // DONE: hold flags, ignore in_valid until restart.
                    in_ready <= 1'b0;
                    ram_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_writer.sv
// Scoreboard bench for program_writer: expected RAM writes are queued when
// words are issued and a negedge monitor pops/compares every ram_we beat.
module tb_program_writer;
    import program_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        in_last = 1'b0;
    logic        restart = 1'b0;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        load_done;
    logic        overflow;
    logic [8:0]  byte_count;

    program_writer #(.RAMSIZE(64), .ADDRW(8)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_last(in_last), .restart(restart),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .load_done(load_done), .overflow(overflow), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    // Hand-computed RAM image: 4 instructions then two float data words.
    logic [7:0] img [24] = '{
        8'h02, 8'h00, 8'h10, 8'h00,  8'h02, 8'h01, 8'h14, 8'h00,
        8'h06, 8'h00, 8'h01, 8'h00,  8'h05, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7a, 8'h44,  8'h00, 8'h00, 8'h20, 8'hc1 };
    logic [31:0] words [6];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every write beat must match the oldest expected write.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (rst_n && ram_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                if (ram_addr !== e.a || ram_wdata !== e.d) begin
                    bad++;
                    $display("FAIL ram_write: got addr=%0h data=%0h want addr=%0h data=%0h",
                             ram_addr, ram_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back('{a: 8'(a), d: d});
    endtask

    // Present a word (leaves in_valid high); returns the cycle of the accept edge.
    task automatic send(input logic [31:0] w, input logic l, output int acc);
        in_word  = w;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready=%0b want 1 within 40 cycles", in_ready);
        acc = -1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        int acc;
        int accs [17];

        words[0] = {16'h0010, 8'h00, OP_MOV_RM};
        words[1] = {16'h0014, 8'h01, OP_MOV_RM};
        words[2] = {16'h0001, 8'h00, OP_FADD};
        words[3] = {16'h0000, 8'h00, OP_SETDEBUG};
        words[4] = 32'h447a0000;
        words[5] = 32'hc1200000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_byte_count", byte_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Image 1: 4 instructions, last on the 4th
        for (int i = 0; i < 16; i++) push(i, img[i]);
        for (int i = 0; i < 4; i++) send(words[i], i == 3, acc);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("img1_byte3_we", ram_we, 1);
        chk("img1_byte3_addr", ram_addr, 15);
        chk("img1_done_early", load_done, 0);
        @(posedge clk);
        #1;
        chk("img1_we_off", ram_we, 0);
        chk("img1_load_done", load_done, 1);
        chk("img1_byte_count", byte_count, 16);
        chk("img1_done_ready", in_ready, 0);

        // Restart from DONE
        pulse_restart();
        chk("rs_done_ready", in_ready, 1);
        chk("rs_done_load_done", load_done, 0);
        chk("rs_done_byte_count", byte_count, 0);

        // Image 2: instructions plus data words
        for (int i = 0; i < 24; i++) push(i, img[i]);
        for (int i = 0; i < 6; i++) send(words[i], i == 5, acc);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("img2_load_done", load_done, 1);
        chk("img2_byte_count", byte_count, 24);

        // Stream 16 words back to back, then a 17th that cannot fit
        pulse_restart();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) push(4*i + k, 8'(4*i + k));
            send({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0, accs[i]);
        end
        send(32'hdeadbeef, 1'b1, accs[16]);
        in_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_load_done", load_done, 0);
        chk("ovf_no_we", ram_we, 0);
        chk("ovf_ready", in_ready, 0);
        for (int i = 1; i < 17; i++) chk("stream_spacing", accs[i] - accs[i-1], 5);
        repeat (6) @(posedge clk);
        #1;
        chk("ovf_byte_count", byte_count, 64);
        chk("ovf_sticky", overflow, 1);

        // Restart together with in_valid in IDLE: word must not be taken
        pulse_restart();
        chk("rs_ovf_cleared", overflow, 0);
        in_word  = 32'h55555555;
        in_valid = 1'b1;
        pulse_restart();
        in_valid = 1'b0;
        chk("rs_valid_ready", in_ready, 1);
        chk("rs_valid_no_we", ram_we, 0);
        repeat (3) @(posedge clk);
        #1;

        // Restart during WR1: bytes 0,1 written, then next word lands at 0
        push(0, 8'h11);
        push(1, 8'h22);
        send(32'h44332211, 1'b0, acc);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        pulse_restart();
        chk("rs_wr1_we", ram_we, 0);
        chk("rs_wr1_ready", in_ready, 1);
        chk("rs_wr1_byte_count", byte_count, 0);
        push(0, 8'hd0); push(1, 8'hc0); push(2, 8'hb0); push(3, 8'ha0);
        send(32'ha0b0c0d0, 1'b1, acc);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rs_wr1_load_done", load_done, 1);
        chk("rs_wr1_count", byte_count, 4);

        // Asynchronous reset in the middle of WR2 of word 1
        pulse_restart();
        push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
        push(4, 8'h14); push(5, 8'h15);
        send(32'h13121110, 1'b0, acc);
        send(32'h17161514, 1'b0, acc);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_we", ram_we, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_byte_count", byte_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rel_ready", in_ready, 1);
        chk("arst_rel_ptr", byte_count, 0);
        repeat (5) @(posedge clk);
        #1;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
